fifo_tx_serializer: RTL and testbench

//  Downstream consumer of the 8-bit synchronous FIFO. Pops one word at a time and

---
 rtl/fifo_tx_serializer.sv | 191 +++++++++++++++++++
 tb/tb_fifo_tx_serializer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_tx_serializer.sv
// fifo_tx_serializer: pops bytes from a synchronous FIFO and sends each
// as a UART-style frame (start, data LSB-first, [even parity], stop).
// Optional feature macro: TX_PARITY_EN (adds an even-parity bit).
// Ports:
//   i_clk, i_rst_n      clock, synchronous active-low reset
//   i_tx_en             permit starting a new frame (sampled in IDLE)
//   i_fifo_empty        FIFO has no data
//   o_fifo_rd_en        one-cycle pop request
//   i_fifo_rd_data      FIFO read data, valid the cycle after the pop
//   o_tx_serial         serial line, idle high
//   o_busy              high from FETCH through the last STOP cycle
//   o_frame_done        pulse in the last STOP cycle
module fifo_tx_serializer #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_tx_en,
    input  logic              i_fifo_empty,
    output logic              o_fifo_rd_en,
    input  logic [DATA_W-1:0] i_fifo_rd_data,
    output logic              o_tx_serial,
    output logic              o_busy,
    output logic              o_frame_done
);

    localparam int DIV_W =
        (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W = $clog2(DATA_W + 1);
    localparam logic [DIV_W-1:0] DIV_LAST =
        DIV_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST =
        BIT_W'(DATA_W - 1);

`ifdef TX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_START,
        S_DATA,
        S_STOP
    } state_t;
`endif

    state_t            r_state;
    logic [DIV_W-1:0]  r_div;
    logic [BIT_W-1:0]  r_bit;
    logic [DATA_W-1:0] r_shift;
    logic              r_tx;
    logic              r_rd_en;
    logic              r_busy;
    logic              r_done;
`ifdef TX_PARITY_EN
    logic              r_par;
`endif

    state_t            w_state_nxt;
    logic [DIV_W-1:0]  w_div_nxt;
    logic [BIT_W-1:0]  w_bit_nxt;
    logic [DATA_W-1:0] w_shift_nxt;
    logic              w_div_end;
    logic              w_tx_nxt;
    logic              w_done_nxt;

    assign w_div_end = (r_div == DIV_LAST);

    always_comb begin
        w_state_nxt = r_state;
        w_div_nxt   = r_div;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        unique case (r_state)
            S_IDLE: begin
                if (i_tx_en && !i_fifo_empty)
                    w_state_nxt = S_FETCH;
            end
            S_FETCH: w_state_nxt = S_LOAD;
            S_LOAD: begin
                w_state_nxt = S_START;
                w_shift_nxt = i_fifo_rd_data;
            end
            S_START: begin
                if (w_div_end)
                    w_state_nxt = S_DATA;
                else
                    w_div_nxt = r_div + 1'b1;
            end
            S_DATA: begin
                if (w_div_end) begin
                    w_div_nxt   = '0;
                    w_shift_nxt = r_shift >> 1;
                    if (r_bit == BIT_LAST) begin
`ifdef TX_PARITY_EN
                        w_state_nxt = S_PARITY;
`else
                        w_state_nxt = S_STOP;
`endif
                    end else begin
                        w_bit_nxt = r_bit + 1'b1;
                    end
                end else begin
                    w_div_nxt = r_div + 1'b1;
                end
            end
`ifdef TX_PARITY_EN
            S_PARITY: begin
                if (w_div_end)
                    w_state_nxt = S_STOP;
                else
                    w_div_nxt = r_div + 1'b1;
            end
`endif
            S_STOP: begin
                if (w_div_end)
                    w_state_nxt = S_IDLE;
                else
                    w_div_nxt = r_div + 1'b1;
            end
            default: w_state_nxt = S_IDLE;
        endcase

        if (w_state_nxt != r_state)
            w_div_nxt = '0;
        if (w_state_nxt != S_DATA)
            w_bit_nxt = '0;
    end

    // Outputs are registered, so they are decoded from the next state.
    always_comb begin
        w_tx_nxt = 1'b1;
        unique case (w_state_nxt)
            S_START: w_tx_nxt = 1'b0;
            S_DATA:  w_tx_nxt = w_shift_nxt[0];
`ifdef TX_PARITY_EN
            S_PARITY: w_tx_nxt = r_par;
`endif
            default: w_tx_nxt = 1'b1;
        endcase
        w_done_nxt = (w_state_nxt == S_STOP) &&
                     (w_div_nxt == DIV_LAST);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_div   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
            r_rd_en <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_div   <= w_div_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_tx    <= w_tx_nxt;
            r_rd_en <= (w_state_nxt == S_FETCH);
            r_busy  <= (w_state_nxt != S_IDLE);
            r_done  <= w_done_nxt;
        end
    end

`ifdef TX_PARITY_EN
    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            r_par <= 1'b0;
        else if (r_state == S_LOAD)
            r_par <= ^i_fifo_rd_data;
    end
`endif

    assign o_fifo_rd_en = r_rd_en;
    assign o_tx_serial  = r_tx;
    assign o_busy       = r_busy;
    assign o_frame_done = r_done;

endmodule

// File: tb/tb_fifo_tx_serializer.sv
// tb_fifo_tx_serializer: directed bench for fifo_tx_serializer
// with a small behavioural FIFO on the read side.
module tb_fifo_tx_serializer;

    localparam int DW  = 8;
    localparam int CPB = 4;
`ifdef TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int PERIOD = NB * CPB + 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tx_en = 1'b0;
    logic       fifo_empty;
    logic       fifo_rd_en;
    logic [7:0] rd_data = 8'h00;
    logic       tx_serial;
    logic       busy;
    logic       frame_done;

    logic [7:0] mem [16];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int underflow = 0;
    int cyc = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] data;
        logic [9:0] seq;
        logic       par;
    } vec_t;
    vec_t vt [7];

    fifo_tx_serializer #(
        .DATA_W(DW),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_tx_en(tx_en),
        .i_fifo_empty(fifo_empty),
        .o_fifo_rd_en(fifo_rd_en),
        .i_fifo_rd_data(rd_data),
        .o_tx_serial(tx_serial),
        .o_busy(busy),
        .o_frame_done(frame_done)
    );

    always #5 clk = ~clk;

    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fifo_rd_en) begin
            if (wr_ptr == rd_ptr) begin
                underflow <= underflow + 1;
            end else begin
                rd_data <= mem[rd_ptr % 16];
                rd_ptr  <= rd_ptr + 1;
            end
        end
    end

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d",
                     name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] w);
        mem[wr_ptr % 16] = w;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic wait_pop(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (fifo_rd_en) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic send_frame(input int k);
        bit ok;
        int p0;
        int bitbad;
        int donebad;
        int busybad;
        logic [9:0] s;
        logic expb;
        s = vt[k].seq;
        p0 = rd_ptr;
        donebad = 0;
        busybad = 0;
        push(vt[k].data);
        tx_en = 1'b1;
        wait_pop(ok);
        check($sformatf("pop_seen_%0d", k), 32'(ok), 1);
        @(negedge clk);
        check($sformatf("load_line_%0d", k),
              32'(tx_serial), 1);
        for (int i = 0; i < NB; i++) begin
            if (NB == 11 && i == 9)
                expb = vt[k].par;
            else if (i == NB - 1)
                expb = 1'b1;
            else
                expb = s[9-i];
            bitbad = 0;
            for (int c = 0; c < CPB; c++) begin
                @(negedge clk);
                if (tx_serial !== expb)
                    bitbad++;
                if (frame_done !==
                    (i == NB - 1 && c == CPB - 1))
                    donebad++;
                if (busy !== 1'b1)
                    busybad++;
            end
            check($sformatf("frame%0d_bit%0d", k, i),
                  32'(bitbad), 0);
        end
        check($sformatf("done_pulse_%0d", k),
              32'(donebad), 0);
        check($sformatf("busy_frame_%0d", k),
              32'(busybad), 0);
        @(negedge clk);
        check($sformatf("idle_busy_%0d", k), 32'(busy), 0);
        check($sformatf("idle_line_%0d", k),
              32'(tx_serial), 1);
        check($sformatf("one_pop_%0d", k),
              32'(rd_ptr - p0), 1);
    endtask

    initial begin
        bit ok;
        int n;
        int extra;
        int t [3];
        int bad_rd;
        int bad_tx;
        int bad_busy;
        int p0;
        bit done_seen;

        vt[0] = '{8'hA5, 10'b0101001011, 1'b0};
        vt[1] = '{8'h07, 10'b0111000001, 1'b1};
        vt[2] = '{8'h03, 10'b0110000001, 1'b0};
        vt[3] = '{8'hFF, 10'b0111111111, 1'b0};
        vt[4] = '{8'h00, 10'b0000000001, 1'b0};
        vt[5] = '{8'h3C, 10'b0001111001, 1'b0};
        vt[6] = '{8'h80, 10'b0000000011, 1'b1};

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(tx_serial), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_rd_en", 32'(fifo_rd_en), 0);
        check("rst_done", 32'(frame_done), 0);
        rst_n = 1'b1;

        tx_en = 1'b1;
        bad_rd = 0;
        bad_tx = 0;
        bad_busy = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (fifo_rd_en !== 1'b0) bad_rd++;
            if (tx_serial !== 1'b1) bad_tx++;
            if (busy !== 1'b0) bad_busy++;
        end
        check("empty_no_pop", 32'(bad_rd), 0);
        check("empty_line_high", 32'(bad_tx), 0);
        check("empty_not_busy", 32'(bad_busy), 0);

        for (int k = 0; k < 7; k++)
            send_frame(k);

        tx_en = 1'b0;
        @(negedge clk);
        p0 = rd_ptr;
        push(8'h11);
        push(8'h22);
        push(8'h33);
        tx_en = 1'b1;
        n = 0;
        extra = 0;
        for (int i = 0; i < 3 * PERIOD + 40; i++) begin
            @(negedge clk);
            if (fifo_rd_en) begin
                if (n < 3) t[n] = cyc;
                else extra++;
                n++;
            end
        end
        check("b2b_pops", 32'(n), 3);
        check("b2b_extra", 32'(extra), 0);
        check("b2b_gap01", 32'(t[1] - t[0]), PERIOD);
        check("b2b_gap12", 32'(t[2] - t[1]), PERIOD);
        check("b2b_fifo", 32'(rd_ptr - p0), 3);

        tx_en = 1'b0;
        p0 = rd_ptr;
        push(8'h5A);
        push(8'hC3);
        tx_en = 1'b1;
        wait_pop(ok);
        check("drop_pop", 32'(ok), 1);
        tx_en = 1'b0;
        done_seen = 1'b0;
        bad_rd = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (frame_done) done_seen = 1'b1;
            if (fifo_rd_en) bad_rd++;
        end
        check("drop_completes", 32'(done_seen), 1);
        check("drop_no_fetch", 32'(bad_rd), 0);
        check("drop_idle", 32'(busy), 0);
        check("drop_one_pop", 32'(rd_ptr - p0), 1);
        tx_en = 1'b1;
        wait_pop(ok);
        check("resume_pop", 32'(ok), 1);
        done_seen = 1'b0;
        for (int i = 0; i < PERIOD + 5; i++) begin
            @(negedge clk);
            if (frame_done) done_seen = 1'b1;
        end
        check("resume_done", 32'(done_seen), 1);

        p0 = rd_ptr;
        push(8'hA5);
        wait_pop(ok);
        check("rstmid_pop", 32'(ok), 1);
        repeat (12) @(negedge clk);
        check("rstmid_busy_pre", 32'(busy), 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("rstmid_tx", 32'(tx_serial), 1);
        check("rstmid_busy", 32'(busy), 0);
        check("rstmid_rd_en", 32'(fifo_rd_en), 0);
        check("rstmid_done", 32'(frame_done), 0);
        rst_n = 1'b1;
        bad_busy = 0;
        bad_tx = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (busy !== 1'b0) bad_busy++;
            if (tx_serial !== 1'b1) bad_tx++;
        end
        check("rstmid_stays_idle", 32'(bad_busy), 0);
        check("rstmid_line", 32'(bad_tx), 0);
        check("rstmid_no_reread", 32'(rd_ptr - p0), 1);
        check("no_underflow", 32'(underflow), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
